shifter_arbiter: RTL and testbench



---
 rtl/shifter_arbiter.sv | 148 ++++++++++++++
 tb/tb_shifter_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester round-robin front end for one shared,
// combinational barrel shifter. One request in flight at a time:
// accept -> drive shifter from registers -> capture -> hold response.
// Barrel_Shifter is the shifter the arbiter is wired to through BS_*.

module Barrel_Shifter #(
  parameter int IWIDTH = 32,
  parameter int SWIDTH = 5
) (
  input  logic              BS_DIR,
  input  logic [SWIDTH-1:0] BS_AMT,
  input  logic [IWIDTH-1:0] D_IN,
  output logic [IWIDTH-1:0] D_OUT
);

  // Arithmetic right shift is computed in its own signed net so the
  // sign fill is not lost to unsigned context in the select below.
  logic signed [IWIDTH-1:0] sra;
  assign sra   = $signed(D_IN) >>> BS_AMT;
  assign D_OUT = BS_DIR ? IWIDTH'(sra) : (D_IN << BS_AMT);

endmodule

module shifter_arbiter #(
  parameter int IWIDTH = 32,
  parameter int SWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_DIR,
  input  logic [SWIDTH-1:0] REQ0_AMT,
  input  logic [IWIDTH-1:0] REQ0_DATA,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_DIR,
  input  logic [SWIDTH-1:0] REQ1_AMT,
  input  logic [IWIDTH-1:0] REQ1_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [IWIDTH-1:0] RSP_DATA,
  output logic              BUSY,
  output logic              BS_DIR,
  output logic [SWIDTH-1:0] BS_AMT,
  output logic [IWIDTH-1:0] BS_D_IN,
  input  logic [IWIDTH-1:0] BS_D_OUT
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic                bs_dir_q, bs_dir_d;
  logic [SWIDTH-1:0]   bs_amt_q, bs_amt_d;
  logic [IWIDTH-1:0]   bs_din_q, bs_din_d;
  logic [IWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                gnt0, gnt1;

  // Round-robin grant, only meaningful in IDLE; on a tie the requester
  // that did not win last time goes first. A grant implies its VALID.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (REQ0_VALID && REQ1_VALID) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = REQ0_VALID;
        gnt1 = REQ1_VALID;
      end
    end
  end

  // Next state and register loads; everything holds unless updated.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    bs_dir_d   = bs_dir_q;
    bs_amt_d   = bs_amt_q;
    bs_din_d   = bs_din_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          bs_dir_d = REQ0_DIR;
          bs_amt_d = REQ0_AMT;
          bs_din_d = REQ0_DATA;
          id_d     = 1'b0;
          last_d   = 1'b0;
          state_d  = SHIFT;
        end else if (gnt1) begin
          bs_dir_d = REQ1_DIR;
          bs_amt_d = REQ1_AMT;
          bs_din_d = REQ1_DATA;
          id_d     = 1'b1;
          last_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Shifter inputs are registered, so its output is settled here.
        rsp_data_d = BS_D_OUT;
        state_d    = RESP;
      end
      RESP: begin
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      bs_dir_q   <= 1'b0;
      bs_amt_q   <= '0;
      bs_din_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      bs_dir_q   <= bs_dir_d;
      bs_amt_q   <= bs_amt_d;
      bs_din_q   <= bs_din_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;
  assign RSP_VALID  = (state_q == RESP);
  assign RSP_ID     = id_q;
  assign RSP_DATA   = rsp_data_q;
  assign BUSY       = (state_q != IDLE);
  assign BS_DIR     = bs_dir_q;
  assign BS_AMT     = bs_amt_q;
  assign BS_D_IN    = bs_din_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed cases plus random traffic, all
// checked each cycle against a transaction-level reference model.

module tb_shifter_arbiter;

  logic        CLK, RST;
  logic        v0, v1, r0, r1, d0, d1;
  logic [4:0]  a0, a1;
  logic [31:0] x0, x1;
  logic        rv, rrdy, rid, busy, bs_dir;
  logic [31:0] rdata, bs_din, bs_dout;
  logic [4:0]  bs_amt;

  shifter_arbiter #(.IWIDTH(32), .SWIDTH(5)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(v0), .REQ0_READY(r0), .REQ0_DIR(d0), .REQ0_AMT(a0), .REQ0_DATA(x0),
    .REQ1_VALID(v1), .REQ1_READY(r1), .REQ1_DIR(d1), .REQ1_AMT(a1), .REQ1_DATA(x1),
    .RSP_VALID(rv), .RSP_READY(rrdy), .RSP_ID(rid), .RSP_DATA(rdata),
    .BUSY(busy), .BS_DIR(bs_dir), .BS_AMT(bs_amt), .BS_D_IN(bs_din), .BS_D_OUT(bs_dout)
  );

  Barrel_Shifter #(.IWIDTH(32), .SWIDTH(5)) u_bs (
    .BS_DIR(bs_dir), .BS_AMT(bs_amt), .D_IN(bs_din), .D_OUT(bs_dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one pending transaction, its age in cycles since
  // accept, its expected result, and the round-robin memory.
  logic        m_pend = 1'b0;
  int          m_age  = 0;
  logic        m_last = 1'b1;
  logic        m_id   = 1'b0;
  logic [31:0] m_data = '0;

  logic log_en = 1'b0;
  int   acc_cyc[$];
  logic rsp_ids[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] shf(input logic dir, input logic [4:0] amt, input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    if (dir) begin
      s = s >>> amt;
      return s;
    end
    return d << amt;
  endfunction

  // One clock: check outputs at negedge, advance model at posedge,
  // return 1 time unit later so callers can drive the next inputs.
  task automatic step();
    logic e0, e1, erv;
    @(negedge CLK);
    e0  = !m_pend && v0 && (!v1 || m_last);
    e1  = !m_pend && v1 && (!v0 || !m_last);
    erv = m_pend && (m_age >= 1);
    chk("rdy0", r0, e0);
    chk("rdy1", r1, e1);
    chk("rspv", rv, erv);
    chk("busy", busy, m_pend);
    if (erv) begin
      chk("rid", rid, m_id);
      chk("rdata", rdata, m_data);
    end
    if (log_en) begin
      if ((v0 && r0) || (v1 && r1)) acc_cyc.push_back(cyc);
      if (rv && rrdy) rsp_ids.push_back(rid);
    end
    @(posedge CLK);
    if (RST) begin
      m_pend = 1'b0;
      m_last = 1'b1;
    end else if (!m_pend) begin
      if (e0) begin
        m_pend = 1'b1; m_age = 0; m_id = 1'b0; m_last = 1'b0; m_data = shf(d0, a0, x0);
      end else if (e1) begin
        m_pend = 1'b1; m_age = 0; m_id = 1'b1; m_last = 1'b1; m_data = shf(d1, a1, x1);
      end
    end else if (m_age >= 1) begin
      if (rrdy) m_pend = 1'b0;
    end else begin
      m_age++;
    end
    cyc++;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"},  rv, 0);
    chk({tag, "_bsy"}, busy, 0);
    chk({tag, "_rid"}, rid, 0);
    chk({tag, "_rd"},  rdata, 0);
    chk({tag, "_bsd"}, bs_dir, 0);
    chk({tag, "_bsa"}, bs_amt, 0);
    chk({tag, "_bsi"}, bs_din, 0);
  endtask

  initial begin
    RST = 1'b1; rrdy = 1'b1;
    v0 = 0; v1 = 0; d0 = 0; d1 = 0; a0 = 0; a1 = 0; x0 = 0; x1 = 0;
    #1;
    chk_zero("rst");
    step(); step();
    RST = 1'b0;

    // Right shift, MSB set, requester 0
    v0 = 1; d0 = 1; a0 = 5'd4; x0 = 32'h8000_0000;
    step();
    v0 = 0;
    step();
    #3;
    chk("r4_v", rv, 1);
    chk("r4_id", rid, 0);
    chk("r4_d", rdata, 32'hF800_0000);
    step();

    // Right shift, MSB clear, requester 1
    v1 = 1; d1 = 1; a1 = 5'd30; x1 = 32'h4000_0000;
    step();
    v1 = 0;
    step();
    #3;
    chk("r30_id", rid, 1);
    chk("r30_d", rdata, 32'h0000_0001);
    step();

    // Left shift sweep over every amount
    for (int k = 0; k < 32; k++) begin
      v0 = 1; d0 = 0; a0 = 5'(k); x0 = 32'h1;
      step();
      v0 = 0;
      step(); step();
    end

    // Fairness: both requesters held valid from reset
    RST = 1'b1;
    step();
    RST = 1'b0; v0 = 1; v1 = 1; d0 = 0; d1 = 1; a0 = 5'd1; a1 = 5'd2;
    x0 = 32'h1234_5678; x1 = 32'h8765_4321; rrdy = 1;
    log_en = 1'b1;
    for (int k = 0; k < 24; k++) step();
    log_en = 1'b0; v0 = 0; v1 = 0;
    step(); step(); step();
    chk("fair_n", (rsp_ids.size() >= 8), 1);
    for (int k = 0; k < 8 && k < rsp_ids.size(); k++) chk("fair_id", rsp_ids[k], k % 2);
    for (int k = 1; k < 8 && k < acc_cyc.size(); k++) chk("fair_gap", acc_cyc[k] - acc_cyc[k-1], 3);

    // Back-pressure: response held for 5 cycles, requests ignored
    v1 = 1; d1 = 0; a1 = 5'd7; x1 = 32'h0000_00F3; rrdy = 0;
    step();
    v1 = 1; v0 = 1;
    step();
    for (int k = 0; k < 5; k++) step();
    rrdy = 1;
    step();
    #1;
    chk("bp_resume", r0 | r1, 1);
    step();
    v0 = 0; v1 = 0;
    step(); step();

    // Reset while in SHIFT: immediate clear, no response afterwards
    v0 = 1; d0 = 1; a0 = 5'd3; x0 = $urandom;
    step();
    v0 = 0;
    #2 RST = 1'b1;
    #1;
    chk_zero("mid");
    chk("mid_r0", r0, 0);
    m_pend = 1'b0; m_last = 1'b1;
    step(); step();
    RST = 1'b0; v0 = 1; v1 = 1;
    #1;
    chk("tie0", r0, 1);
    chk("tie1", r1, 0);
    step();
    v0 = 0; v1 = 0;
    step(); step(); step();

    // Random traffic with random back-pressure
    for (int k = 0; k < 600; k++) begin
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      d0 = 1'($urandom); d1 = 1'($urandom);
      a0 = 5'($urandom); a1 = 5'($urandom);
      x0 = $urandom; x1 = $urandom;
      rrdy = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
